// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// Optional burst hold of up to MAX_BURST words per grant: FIFO_ARB_BURST_EN.
module fifo_wr_arbiter #(
  parameter int WIDTH     = 32,
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 4,
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic                     fifo_full_n,
  output logic                     fifo_write_en,
  output logic [WIDTH-1:0]         fifo_data_in,
  output logic [GW-1:0]            grant_id,
  output logic                     busy
);

  if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
    $error("fifo_wr_arbiter: NUM_REQ out of range");
  end
  if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_max_burst
    $error("fifo_wr_arbiter: MAX_BURST out of range");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e        state_q;
  state_e        state_d;
  logic [GW-1:0] grant_id_q;
  logic [GW-1:0] grant_id_d;

  logic [GW-1:0]    rr_win;
  logic             rr_any;
  logic             in_grant;
  logic             g_valid;
  logic             xfer;
  logic             burst_last;
  logic             rel;
  logic             burst_clr;

  // Scan from the slot after the grantee; the grantee itself comes last.
  always_comb begin
    int idx;
    idx    = 0;
    rr_any = 1'b0;
    rr_win = grant_id_q;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(grant_id_q) + k) % NUM_REQ;
      if (!rr_any && req_valid[idx]) begin
        rr_any = 1'b1;
        rr_win = GW'(idx);
      end
    end
  end

  assign in_grant = (state_q == GRANT);
  assign g_valid  = req_valid[grant_id_q];
  assign xfer     = in_grant & g_valid & fifo_full_n & rst_n;

  // Ready depends only on state, grant and full flag, never on req_valid.
  always_comb begin
    req_ready = '0;
    if (in_grant && rst_n && fifo_full_n) begin
      req_ready[grant_id_q] = 1'b1;
    end
  end

  assign fifo_write_en = xfer;
  assign fifo_data_in  = req_data[grant_id_q*WIDTH +: WIDTH];
  assign grant_id      = grant_id_q;
  assign busy          = in_grant;

`ifdef FIFO_ARB_BURST_EN
  localparam int BW = $clog2(MAX_BURST + 1);

  logic [BW-1:0] burst_cnt_q;
  logic [BW-1:0] burst_cnt_d;

  assign burst_last = xfer && (burst_cnt_q == BW'(MAX_BURST - 1));

  // Count transfers in the current grant; a new grant restarts it.
  always_comb begin
    burst_cnt_d = burst_cnt_q;
    if (burst_clr) begin
      burst_cnt_d = '0;
    end else if (xfer) begin
      burst_cnt_d = burst_cnt_q + BW'(1);
    end
  end

  // Burst counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      burst_cnt_q <= '0;
    end else begin
      burst_cnt_q <= burst_cnt_d;
    end
  end
`else
  assign burst_last = xfer;
`endif

  assign rel = in_grant & (~g_valid | burst_last);

  // Next state: grant on any request, re-arbitrate on release.
  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    burst_clr  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rr_any) begin
          state_d    = GRANT;
          grant_id_d = rr_win;
          burst_clr  = 1'b1;
        end
      end
      GRANT: begin
        if (rel) begin
          if (rr_any) begin
            grant_id_d = rr_win;
            burst_clr  = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and grant registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_id_q <= GW'(NUM_REQ - 1);
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
    end
  end

endmodule
